// File: rtl/otter_mc_ctrl_if.sv
// Control/handshake bundle between the OTTER multicycle controller and the datapath/memories.
// The controller uses the master modport, and the datapath side uses the slave modport.
interface otter_mc_ctrl_if;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       intr;
    logic       mie;
    logic       imem_ready;
    logic       dmem_ready;

    logic       mem_rden1;
    logic       mem_rden2;
    logic       mem_we2;
    logic       alu_srcA;
    logic [2:0] alu_srcB;
    logic       pc_write;
    logic       reg_write;
    logic       csr_we;
    logic       int_taken;
    logic       mret_exec;
    logic       illegal_op;
    logic       bus_err;

    modport master (
        input  opcode, func3, intr, mie, imem_ready, dmem_ready,
        output mem_rden1, mem_rden2, mem_we2, alu_srcA, alu_srcB,
               pc_write, reg_write, csr_we, int_taken, mret_exec, illegal_op, bus_err
    );

    modport slave (
        output opcode, func3, intr, mie, imem_ready, dmem_ready,
        input  mem_rden1, mem_rden2, mem_we2, alu_srcA, alu_srcB,
               pc_write, reg_write, csr_we, int_taken, mret_exec, illegal_op, bus_err
    );
endinterface

// File: rtl/otter_mc_ctrl_fsm.sv
// Multicycle control FSM for the OTTER RV32I core: fetch, execute, memory, writeback, interrupt entry.
// Outputs decode combinationally from the state register, opcode and func3.
module otter_mc_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    otter_mc_ctrl_if.master bus
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_WB    = 3'd3,
        S_INTR  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       tmo_hit;
    logic       is_load;
    logic       sel_a;
    logic [2:0] sel_b;
    state_e     done_state;

    // Wait counter reaching its limit; a zero limit disables the timeout
    assign tmo_hit    = (MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
    assign is_load    = (bus.opcode == OP_LOAD);
    assign done_state = (bus.intr && bus.mie) ? S_INTR : S_FETCH;

    // Operand selects depend only on opcode, so they stay put through MEM and WB
    always_comb begin
        sel_a = 1'b0;
        sel_b = 3'b000;
        case (bus.opcode)
            OP_IMM, OP_LOAD, OP_JALR: sel_b = 3'b001;
            OP_STORE:                 sel_b = 3'b010;
            OP_AUIPC: begin
                sel_a = 1'b1;
                sel_b = 3'b011;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = '0;
        bus.mem_rden1  = 1'b0;
        bus.mem_rden2  = 1'b0;
        bus.mem_we2    = 1'b0;
        bus.alu_srcA   = 1'b0;
        bus.alu_srcB   = 3'b000;
        bus.pc_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.csr_we     = 1'b0;
        bus.int_taken  = 1'b0;
        bus.mret_exec  = 1'b0;
        bus.illegal_op = 1'b0;
        bus.bus_err    = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (bus.imem_ready) begin
                    bus.mem_rden1 = 1'b1;
                    state_d       = S_EXEC;
                end else if (tmo_hit) begin
                    bus.bus_err  = 1'b1;
                    bus.pc_write = 1'b1;
                    state_d      = done_state;
                end else begin
                    bus.mem_rden1 = 1'b1;
                    cnt_d         = cnt_q + CNT_W'(1);
                end
            end

            S_EXEC: begin
                bus.alu_srcA = sel_a;
                bus.alu_srcB = sel_b;
                state_d      = done_state;
                case (bus.opcode)
                    OP_R, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
                        bus.pc_write  = 1'b1;
                        bus.reg_write = 1'b1;
                    end
                    OP_BRANCH: bus.pc_write = 1'b1;
                    OP_LOAD: begin
                        bus.mem_rden2 = 1'b1;
                        state_d       = S_MEM;
                    end
                    OP_STORE: begin
                        bus.mem_we2 = 1'b1;
                        state_d     = S_MEM;
                    end
                    OP_SYSTEM: begin
                        bus.pc_write = 1'b1;
                        if (bus.func3 == 3'b000) begin
                            bus.mret_exec = 1'b1;
                        end else begin
                            bus.csr_we    = 1'b1;
                            bus.reg_write = 1'b1;
                        end
                    end
                    default: begin
                        bus.illegal_op = 1'b1;
                        bus.pc_write   = 1'b1;
                    end
                endcase
            end

            S_MEM: begin
                bus.alu_srcA = sel_a;
                bus.alu_srcB = sel_b;
                if (bus.dmem_ready) begin
                    if (is_load) begin
                        bus.mem_rden2 = 1'b1;
                        state_d       = S_WB;
                    end else begin
                        bus.mem_we2  = 1'b1;
                        bus.pc_write = 1'b1;
                        state_d      = done_state;
                    end
                end else if (tmo_hit) begin
                    bus.bus_err  = 1'b1;
                    bus.pc_write = 1'b1;
                    state_d      = done_state;
                end else begin
                    bus.mem_rden2 = is_load;
                    bus.mem_we2   = !is_load;
                    cnt_d         = cnt_q + CNT_W'(1);
                end
            end

            S_WB: begin
                bus.alu_srcA  = sel_a;
                bus.alu_srcB  = sel_b;
                bus.reg_write = 1'b1;
                bus.pc_write  = 1'b1;
                state_d       = done_state;
            end

            S_INTR: begin
                bus.int_taken = 1'b1;
                bus.pc_write  = 1'b1;
                state_d       = S_FETCH;
            end

            default: state_d = S_FETCH;
        endcase

        // Strobes are held quiet for as long as reset is asserted, including mid-access
        if (!rst_n) begin
            bus.mem_rden1  = 1'b0;
            bus.mem_rden2  = 1'b0;
            bus.mem_we2    = 1'b0;
            bus.alu_srcA   = 1'b0;
            bus.alu_srcB   = 3'b000;
            bus.pc_write   = 1'b0;
            bus.reg_write  = 1'b0;
            bus.csr_we     = 1'b0;
            bus.int_taken  = 1'b0;
            bus.mret_exec  = 1'b0;
            bus.illegal_op = 1'b0;
            bus.bus_err    = 1'b0;
        end
    end

endmodule
